// File: rtl/packet_filter_pkg.sv
// -----------------------------------------------------------------------------
// packet_filter_pkg
// Shared types and helpers for the packet filter.
//   fsm_state_t    : write-side FSM states (IDLE, STORE, DISCARD)
//   pf_word_t      : buffer word layout {sop, eop, empty, data} for the default
//                    64-bit / 3-bit-empty configuration
//   pf_word_width(): buffer word width for any DATA_W / EMPTY_W pair
// -----------------------------------------------------------------------------
package packet_filter_pkg;

  localparam int PF_DATA_W_DEF  = 64;
  localparam int PF_EMPTY_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STORE   = 2'd1,
    DISCARD = 2'd2
  } fsm_state_t;

  typedef struct packed {
    logic                      sop;
    logic                      eop;
    logic [PF_EMPTY_W_DEF-1:0] empty;
    logic [PF_DATA_W_DEF-1:0]  data;
  } pf_word_t;

  function automatic int pf_word_width(input int data_w, input int empty_w);
    return data_w + empty_w + 2;
  endfunction

  localparam int PF_WORD_W = pf_word_width(PF_DATA_W_DEF, PF_EMPTY_W_DEF);

endpackage

// File: rtl/packet_filter_ram.sv
// -----------------------------------------------------------------------------
// packet_filter_ram
// Simple dual-port packet buffer: one write port, one read port, registered
// read data (1-cycle latency). Storage array has no reset.
//   i_clk    : clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write word
//   i_re     : read enable, o_rdata updates on the next edge
//   i_raddr  : read address
//   o_rdata  : read word
// -----------------------------------------------------------------------------
module packet_filter_ram
  import packet_filter_pkg::*;
#(
  parameter int WORD_W = PF_WORD_W,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [0:(2**ADDR_W)-1];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/packet_filter.sv
// -----------------------------------------------------------------------------
// packet_filter
// Buffers each Avalon-ST packet and decides at EOP whether to keep it, based on
// the sticky OR of the classifier channel flag over all beats of the packet.
// Kept packets are released to the source whole; others are rewound away.
//   clk_i / rst_n_i                : clock, async active-low reset
//   ast_*_i (sink)                 : data/valid/sop/eop/empty/channel in
//   ast_ready_o                    : sink ready, 1 outside reset (no backpressure)
//   ast_ready_i                    : source ready
//   ast_*_o (source)               : data/valid/sop/eop/empty out
//   pkt_pass_cnt_o / pkt_drop_cnt_o: wrapping committed / discarded counters
// -----------------------------------------------------------------------------
module packet_filter
  import packet_filter_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int EMPTY_W = 3,
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [DATA_W-1:0]  ast_data_i,
  input  logic               ast_valid_i,
  input  logic               ast_startofpacket_i,
  input  logic               ast_endofpacket_i,
  input  logic [EMPTY_W-1:0] ast_empty_i,
  input  logic               ast_channel_i,
  output logic               ast_ready_o,
  input  logic               ast_ready_i,
  output logic [DATA_W-1:0]  ast_data_o,
  output logic               ast_valid_o,
  output logic               ast_startofpacket_o,
  output logic               ast_endofpacket_o,
  output logic [EMPTY_W-1:0] ast_empty_o,
  output logic [CNT_W-1:0]   pkt_pass_cnt_o,
  output logic [CNT_W-1:0]   pkt_drop_cnt_o
);

  localparam int WORD_W = pf_word_width(DATA_W, EMPTY_W);
  localparam int PTR_W  = ADDR_W + 1;

  // Control registers
  fsm_state_t         r_state;
  logic               r_ready;
  logic               r_keep;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_commit_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_pass_cnt;
  logic [CNT_W-1:0]   r_drop_cnt;
  logic               r_rd_vld_p1;
  logic [1:0]         r_occ;
  logic [WORD_W-1:0]  r_q0;
  logic [WORD_W-1:0]  r_q1;

  // Write-side next-state
  fsm_state_t         w_state_nxt;
  logic [PTR_W-1:0]   w_wr_ptr_nxt;
  logic [PTR_W-1:0]   w_commit_nxt;
  logic               w_keep_nxt;
  logic               w_keep_eff;
  logic               w_we;
  logic [ADDR_W-1:0]  w_waddr;
  logic               w_pass_inc;
  logic               w_drop_inc;
  logic               w_accept;
  logic [PTR_W-1:0]   w_wr_p1;
  logic [PTR_W-1:0]   w_base_p1;
  logic               w_wr_full;
  logic               w_base_full;
  logic [WORD_W-1:0]  w_wdata;

  // Read side
  logic               w_have;
  logic               w_pop;
  logic [1:0]         w_level;
  logic               w_rd_en;
  logic [WORD_W-1:0]  w_rdata;

  assign w_accept  = ast_valid_i & r_ready;
  assign w_wr_p1   = r_wr_ptr + PTR_W'(1);
  assign w_base_p1 = r_commit_ptr + PTR_W'(1);
  // Full compares only the address bits: one slot is always kept empty.
  assign w_wr_full   = (w_wr_p1[ADDR_W-1:0]   == r_rd_ptr[ADDR_W-1:0]);
  assign w_base_full = (w_base_p1[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign w_wdata   = {ast_startofpacket_i, ast_endofpacket_i, ast_empty_i, ast_data_i};

  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_commit_nxt = r_commit_ptr;
    w_keep_nxt   = r_keep;
    w_we         = 1'b0;
    w_waddr      = r_wr_ptr[ADDR_W-1:0];
    w_pass_inc   = 1'b0;
    w_drop_inc   = 1'b0;
    w_keep_eff   = r_keep | ast_channel_i;
    if (w_accept) begin
      if (ast_startofpacket_i) begin
        // A new SOP abandons any open packet; the new one always starts at
        // commit_ptr. An abandon coinciding with a dropped single-beat packet
        // is counted once since the counter moves at most once per cycle.
        if (r_state != IDLE) w_drop_inc = 1'b1;
        w_wr_ptr_nxt = r_commit_ptr;
        w_keep_nxt   = 1'b0;
        if (w_base_full) begin
          if (ast_endofpacket_i) begin
            w_drop_inc  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = DISCARD;
          end
        end else begin
          w_we    = 1'b1;
          w_waddr = r_commit_ptr[ADDR_W-1:0];
          if (ast_endofpacket_i) begin
            w_state_nxt = IDLE;
            if (ast_channel_i) begin
              w_commit_nxt = w_base_p1;
              w_wr_ptr_nxt = w_base_p1;
              w_pass_inc   = 1'b1;
            end else begin
              w_drop_inc = 1'b1;
            end
          end else begin
            w_wr_ptr_nxt = w_base_p1;
            w_keep_nxt   = ast_channel_i;
            w_state_nxt  = STORE;
          end
        end
      end else begin
        case (r_state)
          STORE: begin
            if (w_wr_full) begin
              w_wr_ptr_nxt = r_commit_ptr;
              w_keep_nxt   = 1'b0;
              if (ast_endofpacket_i) begin
                w_drop_inc  = 1'b1;
                w_state_nxt = IDLE;
              end else begin
                w_state_nxt = DISCARD;
              end
            end else begin
              w_we = 1'b1;
              if (ast_endofpacket_i) begin
                w_state_nxt = IDLE;
                w_keep_nxt  = 1'b0;
                if (w_keep_eff) begin
                  w_commit_nxt = w_wr_p1;
                  w_wr_ptr_nxt = w_wr_p1;
                  w_pass_inc   = 1'b1;
                end else begin
                  w_wr_ptr_nxt = r_commit_ptr;
                  w_drop_inc   = 1'b1;
                end
              end else begin
                w_wr_ptr_nxt = w_wr_p1;
                w_keep_nxt   = w_keep_eff;
              end
            end
          end
          DISCARD: begin
            if (ast_endofpacket_i) begin
              w_drop_inc  = 1'b1;
              w_state_nxt = IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= IDLE;
      r_ready      <= 1'b0;
      r_keep       <= 1'b0;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_pass_cnt   <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ready      <= 1'b1;
      r_keep       <= w_keep_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_commit_ptr <= w_commit_nxt;
      if (w_pass_inc) r_pass_cnt <= r_pass_cnt + CNT_W'(1);
      if (w_drop_inc) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  // ---- stage p0: RAM read issue -------------------------------------------
  // Read uses the registered commit_ptr, so a same-cycle commit is seen next
  // cycle. Issue a read only if the 2-entry output buffer will have room when
  // the data lands, counting a pop happening this cycle.
  assign w_have  = (r_rd_ptr != r_commit_ptr);
  assign w_pop   = (r_occ != 2'd0) & ast_ready_i;
  assign w_level = r_occ + {1'b0, r_rd_vld_p1};
  assign w_rd_en = w_have & ((w_level < 2'd2) | w_pop);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rd_ptr    <= '0;
      r_rd_vld_p1 <= 1'b0;
    end else begin
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_rd_vld_p1 <= w_rd_en;
    end
  end

  packet_filter_ram #(
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (clk_i),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_ptr[ADDR_W-1:0]),
    .o_rdata (w_rdata)
  );

  // ---- stage p1: RAM data into output register + skid ----------------------
  // r_q0 drives the source; r_q1 absorbs the word that was already in flight
  // when the sink stalled.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_occ <= 2'd0;
      r_q0  <= '0;
      r_q1  <= '0;
    end else begin
      case ({r_rd_vld_p1, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_q0 <= w_rdata;
          else               r_q1 <= w_rdata;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_q0  <= r_q1;
          r_occ <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd2) begin
            r_q0 <= r_q1;
            r_q1 <= w_rdata;
          end else begin
            r_q0 <= w_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign ast_ready_o         = r_ready;
  assign ast_valid_o         = (r_occ != 2'd0);
  assign ast_startofpacket_o = r_q0[WORD_W-1];
  assign ast_endofpacket_o   = r_q0[WORD_W-2];
  assign ast_empty_o         = r_q0[WORD_W-2] ? r_q0[DATA_W+EMPTY_W-1:DATA_W] : '0;
  assign ast_data_o          = r_q0[DATA_W-1:0];
  assign pkt_pass_cnt_o      = r_pass_cnt;
  assign pkt_drop_cnt_o      = r_drop_cnt;

endmodule

// File: tb/tb_packet_filter.sv
module tb_packet_filter;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [63:0] ast_data_i = '0;
  logic        ast_valid_i = 1'b0;
  logic        ast_startofpacket_i = 1'b0;
  logic        ast_endofpacket_i = 1'b0;
  logic [2:0]  ast_empty_i = '0;
  logic        ast_channel_i = 1'b0;
  logic        ast_ready_o;
  logic        ast_ready_i = 1'b1;
  logic [63:0] ast_data_o;
  logic        ast_valid_o;
  logic        ast_startofpacket_o;
  logic        ast_endofpacket_o;
  logic [2:0]  ast_empty_o;
  logic [15:0] pkt_pass_cnt_o;
  logic [15:0] pkt_drop_cnt_o;

  int total = 0;
  int bad   = 0;
  int rx    = 0;
  logic [68:0] outq[$];

  packet_filter #(.DATA_W(64), .EMPTY_W(3), .ADDR_W(4), .CNT_W(16)) dut (
    .clk_i               (clk_i),
    .rst_n_i             (rst_n_i),
    .ast_data_i          (ast_data_i),
    .ast_valid_i         (ast_valid_i),
    .ast_startofpacket_i (ast_startofpacket_i),
    .ast_endofpacket_i   (ast_endofpacket_i),
    .ast_empty_i         (ast_empty_i),
    .ast_channel_i       (ast_channel_i),
    .ast_ready_o         (ast_ready_o),
    .ast_ready_i         (ast_ready_i),
    .ast_data_o          (ast_data_o),
    .ast_valid_o         (ast_valid_o),
    .ast_startofpacket_o (ast_startofpacket_o),
    .ast_endofpacket_o   (ast_endofpacket_o),
    .ast_empty_o         (ast_empty_o),
    .pkt_pass_cnt_o      (pkt_pass_cnt_o),
    .pkt_drop_cnt_o      (pkt_drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Record every beat that transfers at the next rising edge.
  always @(negedge clk_i)
    if (rst_n_i && ast_valid_o && ast_ready_i)
      outq.push_back({ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_data_o});

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [68:0] bw(input logic sop, input logic eop,
                                     input logic [2:0] emp, input logic [63:0] d);
    return {sop, eop, emp, d};
  endfunction

  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic [68:0] exp);
    logic [68:0] obs;
    obs = (idx < outq.size()) ? outq[idx] : {69{1'b1}};
    chk(tag, obs, exp);
  endtask

  task automatic beat(input logic [63:0] d, input logic sop, input logic eop,
                      input logic [2:0] emp, input logic ch);
    ast_data_i          = d;
    ast_valid_i         = 1'b1;
    ast_startofpacket_i = sop;
    ast_endofpacket_i   = eop;
    ast_empty_i         = emp;
    ast_channel_i       = ch;
    @(posedge clk_i); #1;
    ast_valid_i         = 1'b0;
    ast_startofpacket_i = 1'b0;
    ast_endofpacket_i   = 1'b0;
    ast_channel_i       = 1'b0;
  endtask

  task automatic wait_q(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (outq.size() < n && c < budget) begin
      @(posedge clk_i); #1;
      c++;
    end
    chk(tag, outq.size(), n);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int c;
    c = 0;
    while (!ast_valid_o && c < budget) begin
      @(posedge clk_i); #1;
      c++;
    end
    chk(tag, ast_valid_o, 1'b1);
  endtask

  function automatic logic [68:0] cur();
    return {ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_data_o};
  endfunction

  initial begin
    logic [63:0] d3 [5];
    logic [63:0] d5 [4];

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", ast_ready_o, 1'b0);
    chk("rst_valid", ast_valid_o, 1'b0);
    chk("rst_pass", pkt_pass_cnt_o, 16'd0);
    chk("rst_drop", pkt_drop_cnt_o, 16'd0);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    chk("ready_after_rst", ast_ready_o, 1'b1);

    // T1: 3-beat kept packet, empty=2 on EOP, non-EOP empty must read 0
    beat(64'h1111_0000_0000_00A1, 1'b1, 1'b0, 3'd5, 1'b0);
    beat(64'h1111_0000_0000_00A2, 1'b0, 1'b0, 3'd5, 1'b0);
    beat(64'h1111_0000_0000_00A3, 1'b0, 1'b1, 3'd2, 1'b1);
    wait_q(rx + 3, 30, "t1_count");
    chk_beat("t1_b0", rx + 0, bw(1'b1, 1'b0, 3'd0, 64'h1111_0000_0000_00A1));
    chk_beat("t1_b1", rx + 1, bw(1'b0, 1'b0, 3'd0, 64'h1111_0000_0000_00A2));
    chk_beat("t1_b2", rx + 2, bw(1'b0, 1'b1, 3'd2, 64'h1111_0000_0000_00A3));
    rx += 3;
    chk("t1_pass", pkt_pass_cnt_o, 16'd1);
    chk("t1_drop", pkt_drop_cnt_o, 16'd0);

    // T2: 4-beat packet, channel 0 throughout -> dropped
    beat(64'h2222_0000_0000_00B1, 1'b1, 1'b0, 3'd0, 1'b0);
    beat(64'h2222_0000_0000_00B2, 1'b0, 1'b0, 3'd0, 1'b0);
    beat(64'h2222_0000_0000_00B3, 1'b0, 1'b0, 3'd0, 1'b0);
    beat(64'h2222_0000_0000_00B4, 1'b0, 1'b1, 3'd1, 1'b0);
    repeat (12) @(posedge clk_i);
    #1;
    chk("t2_no_out", outq.size(), rx);
    chk("t2_drop", pkt_drop_cnt_o, 16'd1);
    chk("t2_pass", pkt_pass_cnt_o, 16'd1);

    // T3: channel pulses only on beat 2 of 5 -> sticky keep
    d3[0] = 64'h3333_0000_0000_00C1; d3[1] = 64'h3333_0000_0000_00C2;
    d3[2] = 64'h3333_0000_0000_00C3; d3[3] = 64'h3333_0000_0000_00C4;
    d3[4] = 64'h3333_0000_0000_00C5;
    for (int i = 0; i < 5; i++)
      beat(d3[i], (i == 0), (i == 4), 3'd0, (i == 1));
    wait_q(rx + 5, 30, "t3_count");
    for (int i = 0; i < 5; i++)
      chk_beat($sformatf("t3_b%0d", i), rx + i, bw((i == 0), (i == 4), 3'd0, d3[i]));
    rx += 5;
    chk("t3_pass", pkt_pass_cnt_o, 16'd2);

    // T4: 20-beat packet overflows a 16-entry buffer -> dropped
    for (int i = 0; i < 20; i++)
      beat(64'h4444_0000_0000_0000 | 64'(i), (i == 0), (i == 19), 3'd0, 1'b1);
    repeat (12) @(posedge clk_i);
    #1;
    chk("t4_no_out", outq.size(), rx);
    chk("t4_drop", pkt_drop_cnt_o, 16'd2);
    beat(64'h4545_0000_0000_00D1, 1'b1, 1'b0, 3'd0, 1'b1);
    beat(64'h4545_0000_0000_00D2, 1'b0, 1'b1, 3'd3, 1'b1);
    wait_q(rx + 2, 30, "t4_count");
    chk_beat("t4_b0", rx + 0, bw(1'b1, 1'b0, 3'd0, 64'h4545_0000_0000_00D1));
    chk_beat("t4_b1", rx + 1, bw(1'b0, 1'b1, 3'd3, 64'h4545_0000_0000_00D2));
    rx += 2;
    chk("t4_pass", pkt_pass_cnt_o, 16'd3);

    // T5: stall handling, ready pattern 1,0,0,1
    d5[0] = 64'h5555_0000_0000_00E1; d5[1] = 64'h5555_0000_0000_00E2;
    d5[2] = 64'h5555_0000_0000_00E3; d5[3] = 64'h5555_0000_0000_00E4;
    ast_ready_i = 1'b0;
    for (int i = 0; i < 4; i++)
      beat(d5[i], (i == 0), (i == 3), 3'd4, 1'b1);
    wait_valid(30, "t5_valid");
    chk("t5_hold0a", cur(), bw(1'b1, 1'b0, 3'd0, d5[0]));
    @(posedge clk_i); #1;
    chk("t5_hold0b", cur(), bw(1'b1, 1'b0, 3'd0, d5[0]));
    ast_ready_i = 1'b1;
    @(posedge clk_i); #1;
    ast_ready_i = 1'b0;
    chk("t5_hold1a", cur(), bw(1'b0, 1'b0, 3'd0, d5[1]));
    @(posedge clk_i); #1;
    chk("t5_hold1b", cur(), bw(1'b0, 1'b0, 3'd0, d5[1]));
    @(posedge clk_i); #1;
    chk("t5_hold1c", cur(), bw(1'b0, 1'b0, 3'd0, d5[1]));
    chk("t5_vld_stall", ast_valid_o, 1'b1);
    ast_ready_i = 1'b1;
    wait_q(rx + 4, 30, "t5_count");
    repeat (4) @(posedge clk_i);
    #1;
    chk("t5_no_dup", outq.size(), rx + 4);
    for (int i = 0; i < 4; i++)
      chk_beat($sformatf("t5_b%0d", i), rx + i, bw((i == 0), (i == 3), (i == 3) ? 3'd4 : 3'd0, d5[i]));
    rx += 4;
    chk("t5_pass", pkt_pass_cnt_o, 16'd4);

    // T6: SOP, 2 beats, then new SOP (single-beat kept) without prior EOP
    beat(64'h6666_0000_0000_00F1, 1'b1, 1'b0, 3'd0, 1'b1);
    beat(64'h6666_0000_0000_00F2, 1'b0, 1'b0, 3'd0, 1'b1);
    beat(64'h6666_0000_0000_00F3, 1'b1, 1'b1, 3'd7, 1'b1);
    wait_q(rx + 1, 30, "t6_count");
    repeat (6) @(posedge clk_i);
    #1;
    chk("t6_only_one", outq.size(), rx + 1);
    chk_beat("t6_b0", rx, bw(1'b1, 1'b1, 3'd7, 64'h6666_0000_0000_00F3));
    rx += 1;
    chk("t6_drop", pkt_drop_cnt_o, 16'd3);
    chk("t6_pass", pkt_pass_cnt_o, 16'd5);

    // Async reset while a packet is being presented on the source
    ast_ready_i = 1'b0;
    beat(64'h7777_0000_0000_0071, 1'b1, 1'b0, 3'd0, 1'b1);
    beat(64'h7777_0000_0000_0072, 1'b0, 1'b1, 3'd1, 1'b1);
    wait_valid(30, "rst_mid_valid_pre");
    #3;
    rst_n_i = 1'b0;
    #1;
    chk("rstm_valid", ast_valid_o, 1'b0);
    chk("rstm_data", ast_data_o, 64'd0);
    chk("rstm_sop", ast_startofpacket_o, 1'b0);
    chk("rstm_eop", ast_endofpacket_o, 1'b0);
    chk("rstm_empty", ast_empty_o, 3'd0);
    chk("rstm_ready", ast_ready_o, 1'b0);
    chk("rstm_pass", pkt_pass_cnt_o, 16'd0);
    chk("rstm_drop", pkt_drop_cnt_o, 16'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    ast_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("post_rst_ready", ast_ready_o, 1'b1);
    chk("post_rst_valid", ast_valid_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
